// File: rtl/conv_channel_accumulator.sv
// conv_channel_accumulator
// Sums a plane-sequential multi-channel convolution stream (channel 0 for the
// whole frame, then channel 1, ...) into one output plane. One FRAME_SIZE-deep
// accumulation RAM holds the running per-pixel partial sums. Channel 0 seeds each
// pixel with the bias. The last channel drives the output through optional ReLU
// and saturation. Input-to-output latency is 2 cycles with no backpressure.
module conv_channel_accumulator #(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAME_SIZE   = 612,
    parameter int MAX_CHANNELS = 1024,
    parameter int RELU_EN      = 0,
    parameter int ACC_WIDTH    = DATA_WIDTH + $clog2(MAX_CHANNELS) + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            valid_in,
    input  logic [DATA_WIDTH-1:0]           pxl_in,
    input  logic [$clog2(MAX_CHANNELS):0]   ch_num,
    input  logic [DATA_WIDTH-1:0]           bias,
    output logic [DATA_WIDTH-1:0]           pxl_out,
    output logic                            valid_out,
    output logic                            last_out,
    output logic                            sat_flag,
    output logic                            busy
);

    localparam int CH_W = $clog2(MAX_CHANNELS) + 1;
    localparam int AW   = $clog2(FRAME_SIZE);

    localparam logic [AW-1:0]   PIX_LAST = AW'(FRAME_SIZE - 1);
    localparam logic [CH_W-1:0] CH_MAX   = CH_W'(MAX_CHANNELS);
    localparam logic [CH_W-1:0] CH_ONE   = CH_W'(1);

    // Output range expressed at accumulator width: DMIN is the bitwise
    // complement of DMAX, i.e. -2^(DATA_WIDTH-1).
    localparam logic signed [ACC_WIDTH-1:0] ACC_DMAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_DMIN = ~ACC_DMAX;

    // Sign-extend a DATA_WIDTH value to the accumulator width.
    function automatic logic signed [ACC_WIDTH-1:0] sext_data(input logic [DATA_WIDTH-1:0] d);
        return {{(ACC_WIDTH - DATA_WIDTH){d[DATA_WIDTH-1]}}, d};
    endfunction

    // Clamp an accumulator value into DATA_WIDTH. The MSB of the result flags
    // that clamping happened.
    function automatic logic [DATA_WIDTH:0] sat_to_data(input logic signed [ACC_WIDTH-1:0] v);
        logic [DATA_WIDTH:0] res;
        if (v > ACC_DMAX) begin
            res = {1'b1, ACC_DMAX[DATA_WIDTH-1:0]};
        end else if (v < ACC_DMIN) begin
            res = {1'b1, ACC_DMIN[DATA_WIDTH-1:0]};
        end else begin
            res = {1'b0, v[DATA_WIDTH-1:0]};
        end
        return res;
    endfunction

    // Frame position and per-frame configuration
    logic [AW-1:0]                r_pix_cnt;
    logic [CH_W-1:0]              r_ch_cnt;
    logic [CH_W-1:0]              r_ch_num;
    logic [DATA_WIDTH-1:0]        r_bias;

    // Stage 1: the registered input plus its position flags
    logic                         r_d_valid;
    logic signed [ACC_WIDTH-1:0]  r_d_pxl;
    logic [AW-1:0]                r_d_addr;
    logic                         r_d_first;
    logic                         r_d_last_ch;
    logic                         r_d_last_pix;

    // Accumulation RAM and its registered read port
    logic signed [ACC_WIDTH-1:0]  r_ram [0:FRAME_SIZE-1];
    logic signed [ACC_WIDTH-1:0]  r_ram_q;

    // Stage 2: write-back of partial sums
    logic                         r_wr_en;
    logic signed [ACC_WIDTH-1:0]  r_s_sum;
    logic [AW-1:0]                r_s_addr;

    // Output registers
    logic [DATA_WIDTH-1:0]        r_pxl_out;
    logic                         r_valid_out;
    logic                         r_last_out;
    logic                         r_sat_flag;
    logic                         r_busy;

    logic                         w_frame_start;
    logic [CH_W-1:0]              w_ch_clamped;
    logic [CH_W-1:0]              w_ch_num_act;
    logic                         w_is_last_ch;
    logic signed [ACC_WIDTH-1:0]  w_base;
    logic signed [ACC_WIDTH-1:0]  w_sum;
    logic signed [ACC_WIDTH-1:0]  w_act;
    logic [DATA_WIDTH:0]          w_sat;
    logic                         w_out_now;

    // Frame-start detection and the channel count in force for this input
    always_comb begin
        w_frame_start = valid_in && (r_pix_cnt == {AW{1'b0}}) && (r_ch_cnt == {CH_W{1'b0}});
        if (ch_num == {CH_W{1'b0}}) begin
            w_ch_clamped = CH_ONE;
        end else if (ch_num > CH_MAX) begin
            w_ch_clamped = CH_MAX;
        end else begin
            w_ch_clamped = ch_num;
        end
        if (w_frame_start) begin
            w_ch_num_act = w_ch_clamped;
        end else begin
            w_ch_num_act = r_ch_num;
        end
        w_is_last_ch = (r_ch_cnt == (w_ch_num_act - CH_ONE));
    end

    // Pixel/channel counters and frame configuration latched at frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_cnt <= {AW{1'b0}};
            r_ch_cnt  <= {CH_W{1'b0}};
            r_ch_num  <= {CH_W{1'b0}};
            r_bias    <= {DATA_WIDTH{1'b0}};
        end else begin
            if (w_frame_start) begin
                r_ch_num <= w_ch_clamped;
                r_bias   <= bias;
            end
            if (valid_in) begin
                if (r_pix_cnt == PIX_LAST) begin
                    r_pix_cnt <= {AW{1'b0}};
                    r_ch_cnt  <= w_is_last_ch ? {CH_W{1'b0}} : (r_ch_cnt + CH_ONE);
                end else begin
                    r_pix_cnt <= r_pix_cnt + AW'(1);
                end
            end
        end
    end

    // Stage 1: capture the sign-extended pixel and where it sits in the frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_valid    <= 1'b0;
            r_d_pxl      <= {ACC_WIDTH{1'b0}};
            r_d_addr     <= {AW{1'b0}};
            r_d_first    <= 1'b0;
            r_d_last_ch  <= 1'b0;
            r_d_last_pix <= 1'b0;
        end else begin
            r_d_valid <= valid_in;
            if (valid_in) begin
                r_d_pxl      <= sext_data(pxl_in);
                r_d_addr     <= r_pix_cnt;
                r_d_first    <= (r_ch_cnt == {CH_W{1'b0}});
                r_d_last_ch  <= w_is_last_ch;
                r_d_last_pix <= (r_pix_cnt == PIX_LAST);
            end
        end
    end

    // RAM read of the partial sum for the pixel being accepted now
    always_ff @(posedge clk) begin
        if (valid_in) begin
            r_ram_q <= r_ram[r_pix_cnt];
        end
    end

    // RAM write-back; a rewritten address is not read again for FRAME_SIZE
    // accepted pixels, so no read-after-write forwarding is needed
    always_ff @(posedge clk) begin
        if (r_wr_en) begin
            r_ram[r_s_addr] <= r_s_sum;
        end
    end

    // Stage 1 arithmetic: seed with bias on channel 0, then ReLU and clamp
    always_comb begin
        if (r_d_first) begin
            w_base = sext_data(r_bias);
        end else begin
            w_base = r_ram_q;
        end
        w_sum = w_base + r_d_pxl;
        if ((RELU_EN != 0) && w_sum[ACC_WIDTH-1]) begin
            w_act = {ACC_WIDTH{1'b0}};
        end else begin
            w_act = w_sum;
        end
        w_sat     = sat_to_data(w_act);
        w_out_now = r_d_valid && r_d_last_ch;
    end

    // Stage 2 registers: partial-sum write-back and the frame outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en     <= 1'b0;
            r_s_sum     <= {ACC_WIDTH{1'b0}};
            r_s_addr    <= {AW{1'b0}};
            r_pxl_out   <= {DATA_WIDTH{1'b0}};
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
            r_sat_flag  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_wr_en     <= r_d_valid && !r_d_last_ch;
            r_s_sum     <= w_sum;
            r_s_addr    <= r_d_addr;
            r_valid_out <= w_out_now;
            r_last_out  <= w_out_now && r_d_last_pix;
            if (w_out_now) begin
                r_pxl_out <= w_sat[DATA_WIDTH-1:0];
            end
            if (w_frame_start) begin
                r_sat_flag <= 1'b0;
            end else if (w_out_now && w_sat[DATA_WIDTH]) begin
                r_sat_flag <= 1'b1;
            end
            if (w_frame_start) begin
                r_busy <= 1'b1;
            end else if (w_out_now && r_d_last_pix) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign pxl_out   = r_pxl_out;
    assign valid_out = r_valid_out;
    assign last_out  = r_last_out;
    assign sat_flag  = r_sat_flag;
    assign busy      = r_busy;

endmodule
